// File: rtl/jesd204_rx_ramp_checker.sv
// JESD204 receive-side ramp checker: self-synchronous 1+x^14+x^15 descrambler
// followed by a HUNT/SYNC/LOCKED ramp tracker with saturating mismatch count.
module jesd204_rx_ramp_checker #(
  parameter int DESCRAMBLE    = 1,
  parameter int LOCK_COUNT    = 4,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     enable,
  input  logic                     in_valid,
  input  logic [31:0]              in_data,
  input  logic                     clear,
  output logic                     out_valid,
  output logic [31:0]              out_data,
  output logic                     locked,
  output logic                     error,
  output logic [ERR_CNT_WIDTH-1:0] error_count,
  output logic [1:0]               state
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [4:0] LOCK_TARGET_C = 5'(LOCK_COUNT + 1);
  localparam logic [1:0] MISS_LIMIT_C  = 2'd3;

  // Serial order walks octet 0 first, MSB first: serial index i maps to bit i^7.
  function automatic logic [46:0] descramble_f(input logic [31:0] data, input logic [14:0] hist);
    logic [14:0] h;
    logic [31:0] d;
    logic [4:0]  p;
    h = hist;
    d = 32'h0000_0000;
    p = 5'd0;
    for (int i = 0; i < 32; i++) begin
      p    = 5'(i) ^ 5'd7;
      d[p] = data[p] ^ h[13] ^ h[14];
      h    = {h[13:0], data[p]};
    end
    return {h, d};
  endfunction

  function automatic logic consistent_f(input logic [31:0] w);
    return (w[15:8]  == 8'(w[7:0] + 8'd1)) &&
           (w[23:16] == 8'(w[7:0] + 8'd2)) &&
           (w[31:24] == 8'(w[7:0] + 8'd3));
  endfunction

  function automatic logic [31:0] add4_f(input logic [31:0] w);
    return {8'(w[31:24] + 8'd4), 8'(w[23:16] + 8'd4),
            8'(w[15:8] + 8'd4), 8'(w[7:0] + 8'd4)};
  endfunction

  logic [14:0]              hist_r;
  logic                     out_valid_r;
  logic [31:0]              out_data_r;
  state_t                   state_r;
  logic                     locked_r;
  logic                     error_r;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_r;
  logic [4:0]               match_cnt_r;
  logic [1:0]               miss_cnt_r;
  logic [31:0]              expected_r;

  logic [46:0]              desc_s;
  logic [31:0]              next_data_s;
  logic                     match_s;
  logic                     consistent_s;
  logic [4:0]               match_next_s;
  logic [1:0]               miss_next_s;
  logic                     cnt_inc_s;

  // Descrambler and next-word selection (bypass still advances history).
  always_comb begin
    desc_s = descramble_f(in_data, hist_r);
    if ((DESCRAMBLE != 0) && enable) begin
      next_data_s = desc_s[31:0];
    end else begin
      next_data_s = in_data;
    end
  end

  // Compare helpers for the tracker, all on the registered output word.
  always_comb begin
    match_s      = (out_data_r == expected_r);
    consistent_s = consistent_f(out_data_r);
    match_next_s = match_cnt_r + 5'd1;
    miss_next_s  = miss_cnt_r + 2'd1;
    if (out_valid_r && (state_r == LOCKED) && !match_s &&
        (err_cnt_r != {ERR_CNT_WIDTH{1'b1}})) begin
      cnt_inc_s = 1'b1;
    end else begin
      cnt_inc_s = 1'b0;
    end
  end

  // Output register and scrambled-bit history.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid_r <= 1'b0;
      out_data_r  <= 32'h0000_0000;
      hist_r      <= 15'h0000;
    end else begin
      out_valid_r <= in_valid;
      if (in_valid) begin
        out_data_r <= next_data_s;
        hist_r     <= desc_s[46:32];
      end
    end
  end

  // Ramp tracker FSM; holds everything when no word is presented.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r     <= HUNT;
      locked_r    <= 1'b0;
      error_r     <= 1'b0;
      match_cnt_r <= 5'd0;
      miss_cnt_r  <= 2'd0;
      expected_r  <= 32'h0000_0000;
    end else begin
      error_r <= 1'b0;
      if (out_valid_r) begin
        case (state_r)
          HUNT: begin
            if (consistent_s) begin
              expected_r  <= add4_f(out_data_r);
              match_cnt_r <= 5'd1;
              state_r     <= SYNC;
            end else begin
              match_cnt_r <= 5'd0;
            end
          end
          SYNC: begin
            if (match_s) begin
              expected_r  <= add4_f(expected_r);
              match_cnt_r <= match_next_s;
              if (match_next_s == LOCK_TARGET_C) begin
                state_r    <= LOCKED;
                locked_r   <= 1'b1;
                miss_cnt_r <= 2'd0;
              end
            end else begin
              state_r     <= HUNT;
              match_cnt_r <= 5'd0;
            end
          end
          LOCKED: begin
            expected_r <= add4_f(expected_r);
            if (!match_s) begin
              error_r <= 1'b1;
              if (miss_next_s == MISS_LIMIT_C) begin
                state_r     <= HUNT;
                locked_r    <= 1'b0;
                match_cnt_r <= 5'd0;
                miss_cnt_r  <= 2'd0;
              end else begin
                miss_cnt_r <= miss_next_s;
              end
            end else begin
              miss_cnt_r <= 2'd0;
            end
          end
          default: begin
            state_r     <= HUNT;
            locked_r    <= 1'b0;
            match_cnt_r <= 5'd0;
            miss_cnt_r  <= 2'd0;
          end
        endcase
      end
    end
  end

  // Saturating mismatch counter; clear wins over a same-cycle mismatch.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_cnt_r <= {ERR_CNT_WIDTH{1'b0}};
    end else if (clear) begin
      err_cnt_r <= {ERR_CNT_WIDTH{1'b0}};
    end else if (cnt_inc_s) begin
      err_cnt_r <= err_cnt_r + {{(ERR_CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign out_valid   = out_valid_r;
  assign out_data    = out_data_r;
  assign locked      = locked_r;
  assign error       = error_r;
  assign error_count = err_cnt_r;
  assign state       = state_r;

endmodule

// File: tb/tb_jesd204_rx_ramp_checker.sv
// Scoreboard bench: a reference scrambler feeds the ramp; expected plaintext is
// queued per word and a negedge monitor compares it against out_data.
module tb_jesd204_rx_ramp_checker;

  logic        clk = 1'b0;
  logic        resetn;
  logic        enable;
  logic        in_valid;
  logic [31:0] in_data;
  logic        clear;
  logic        out_valid;
  logic [31:0] out_data;
  logic        locked;
  logic        error;
  logic [15:0] error_count;
  logic [1:0]  state;

  typedef struct packed {
    logic        chk;
    logic [31:0] data;
  } exp_t;

  exp_t        q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          err_pulses = 0;
  int          ramp_n = 0;
  logic        prev_in_valid = 1'b0;
  logic [14:0] scr_st = 15'h0;

  jesd204_rx_ramp_checker #(
    .DESCRAMBLE(1),
    .LOCK_COUNT(4),
    .ERR_CNT_WIDTH(16)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .enable(enable),
    .in_valid(in_valid),
    .in_data(in_data),
    .clear(clear),
    .out_valid(out_valid),
    .out_data(out_data),
    .locked(locked),
    .error(error),
    .error_count(error_count),
    .state(state)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ramp_f(input int n);
    logic [7:0] b;
    b = 8'(4 * n);
    return {8'(b + 8'd3), 8'(b + 8'd2), 8'(b + 8'd1), b};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Reference JESD204 scrambler: s[n] = d[n] ^ s[n-14] ^ s[n-15].
  task automatic scramble(input logic [31:0] plain, output logic [31:0] s_out);
    logic [4:0] p;
    logic       s;
    s_out = 32'h0;
    for (int i = 0; i < 32; i++) begin
      p        = 5'(i) ^ 5'd7;
      s        = plain[p] ^ scr_st[13] ^ scr_st[14];
      s_out[p] = s;
      scr_st   = {scr_st[13:0], s};
    end
  endtask

  task automatic drive(input logic [31:0] d, input logic en, input logic chk, input logic [31:0] exp);
    exp_t e;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = d;
    enable   = en;
    e.chk    = chk;
    e.data   = exp;
    q.push_back(e);
  endtask

  task automatic send_word(input logic [31:0] flip, input logic [31:0] exp_flip,
                           input logic force_ff, input logic chk);
    logic [31:0] p;
    logic [31:0] s;
    p = ramp_f(ramp_n);
    scramble(p, s);
    ramp_n++;
    if (force_ff) drive(32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0);
    else          drive(s ^ flip, 1'b1, chk, p ^ exp_flip);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  // Ten-word ramp from a fresh scrambler; lock must appear right after word 5.
  task automatic lock_phase();
    for (int j = 0; j < 10; j++) begin
      send_word(32'h0, 32'h0, 1'b0, 1'b1);
      @(negedge clk);
      if (j == 5) check("not_locked_after_4_words", 32'(locked), 32'd0);
      if (j == 6) begin
        check("locked_after_5_words", 32'(locked), 32'd1);
        check("state_locked", 32'(state), 32'd2);
      end
    end
    check("error_count_clean_ramp", 32'(error_count), 32'd0);
  endtask

  // Monitor: scoreboard pop on out_valid, out_valid mirror, error pulse count.
  initial begin
    forever begin
      @(negedge clk);
      if (resetn) begin
        check("out_valid_mirror", 32'(out_valid), 32'(prev_in_valid));
        if (error) err_pulses++;
        if (out_valid) begin
          if (q.size() == 0) begin
            miscompares++;
            $display("FAIL scoreboard_underflow: out_valid with empty queue at %0t", $time);
          end else begin
            exp_t e;
            e = q.pop_front();
            if (e.chk) check("out_data", out_data, e.data);
          end
        end
        prev_in_valid = in_valid;
      end else begin
        prev_in_valid = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    resetn   = 1'b0;
    enable   = 1'b1;
    in_valid = 1'b0;
    in_data  = 32'h0;
    clear    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_state", 32'(state), 32'd0);
    check("rst_error_count", 32'(error_count), 32'd0);
    @(posedge clk);
    #2 resetn = 1'b1;

    lock_phase();

    // Single flipped bit: serial bit 0 also corrupts bits 14 and 15 of the same word.
    send_word(32'h0000_0080, 32'h0000_0380, 1'b0, 1'b1);
    for (int j = 0; j < 3; j++) send_word(32'h0, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    check("flip_error_count", 32'(error_count), 32'd1);
    check("flip_locked", 32'(locked), 32'd1);
    check("flip_err_pulses", 32'(err_pulses), 32'd1);

    // Three all-ones words force the loss of lock.
    for (int j = 0; j < 3; j++) send_word(32'h0, 32'h0, 1'b1, 1'b0);
    send_word(32'h0, 32'h0, 1'b0, 1'b0);
    send_word(32'h0, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    check("ff_state_hunt", 32'(state), 32'd0);
    check("ff_unlocked", 32'(locked), 32'd0);
    check("ff_error_count", 32'(error_count), 32'd4);
    check("ff_err_pulses", 32'(err_pulses), 32'd4);
    for (int j = 0; j < 6; j++) begin
      send_word(32'h0, 32'h0, 1'b0, 1'b1);
      @(negedge clk);
      if (j == 3) check("relock_not_yet", 32'(locked), 32'd0);
    end
    check("relock_locked", 32'(locked), 32'd1);
    check("relock_error_count", 32'(error_count), 32'd4);

    send_word(32'h0000_0080, 32'h0000_0380, 1'b0, 1'b1);
    send_word(32'h0, 32'h0, 1'b0, 1'b1);
    send_word(32'h0, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    check("count_reaches_5", 32'(error_count), 32'd5);

    // Clear lands on the same edge that registers the next mismatch.
    send_word(32'h0000_0080, 32'h0000_0380, 1'b0, 1'b1);
    send_word(32'h0, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    check("count_still_5", 32'(error_count), 32'd5);
    clear = 1'b1;
    send_word(32'h0, 32'h0, 1'b0, 1'b1);
    clear = 1'b0;
    @(negedge clk);
    check("clear_error_pulse", 32'(error), 32'd1);
    check("clear_error_count", 32'(error_count), 32'd0);
    send_word(32'h0, 32'h0, 1'b0, 1'b1);
    send_word(32'h0, 32'h0, 1'b0, 1'b1);

    // Gappy in_valid: 1,0,0,1,... must not disturb lock.
    for (int j = 0; j < 4; j++) begin
      send_word(32'h0, 32'h0, 1'b0, 1'b1);
      idle(2);
    end
    send_word(32'h0, 32'h0, 1'b0, 1'b1);
    send_word(32'h0, 32'h0, 1'b0, 1'b1);
    idle(3);
    @(negedge clk);
    check("gap_locked", 32'(locked), 32'd1);
    check("gap_error_count", 32'(error_count), 32'd0);
    check("gap_err_pulses", 32'(err_pulses), 32'd6);

    // Asynchronous reset in the middle of a locked stream.
    send_word(32'h0000_0080, 32'h0000_0380, 1'b0, 1'b1);
    for (int j = 0; j < 3; j++) send_word(32'h0, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    check("pre_reset_error_count", 32'(error_count), 32'd1);
    send_word(32'h0, 32'h0, 1'b0, 1'b1);
    #2 resetn = 1'b0;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_out_data", out_data, 32'd0);
    check("async_rst_locked", 32'(locked), 32'd0);
    check("async_rst_state", 32'(state), 32'd0);
    check("async_rst_error", 32'(error), 32'd0);
    check("async_rst_error_count", 32'(error_count), 32'd0);
    in_valid = 1'b0;
    q.delete();
    repeat (2) @(posedge clk);
    #2 resetn = 1'b1;
    scr_st = 15'h0;
    ramp_n = 0;
    lock_phase();

    // Bypass passes raw wire data but keeps history, so the next word decodes cleanly.
    begin
      logic [31:0] p;
      logic [31:0] s;
      p = ramp_f(ramp_n);
      scramble(p, s);
      ramp_n++;
      drive(s, 1'b0, 1'b1, s);
    end
    send_word(32'h0, 32'h0, 1'b0, 1'b1);
    idle(3);
    @(negedge clk);
    check("queue_drained", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/jesd204_rx_ramp_checker.md
JESD204_RX_RAMP_CHECKER -- requirements
Module: jesd204_rx_ramp_checker

Interface
REQ-001 SHALL have parameter DESCRAMBLE, default 1; 1 = descramble input, 0 = input passes through unmodified.
REQ-002 SHALL have parameter LOCK_COUNT, default 4; number of consecutive matching words needed to lock (legal range 1..15).
REQ-003 SHALL have parameter ERR_CNT_WIDTH, default 16; width of error_count.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port enable  input  1  descrambler enable; 0 = bypass with descrambler state still updated.
REQ-007 SHALL have port in_valid  input  1  in_data qualifier.
REQ-008 SHALL have port in_data  input  32  scrambled lane data; octet 0 = [7:0] is first in time, bit 7 of each octet is first.
REQ-009 SHALL have port clear  input  1  synchronous clear of error_count.
REQ-010 SHALL have port out_valid  output  1  out_data qualifier.
REQ-011 SHALL have port out_data  output  32  descrambled data.
REQ-012 SHALL have port locked  output  1  checker in LOCKED state.
REQ-013 SHALL have port error  output  1  one-cycle pulse per mismatching word while LOCKED.
REQ-014 SHALL have port error_count  output  ERR_CNT_WIDTH  saturating mismatch count.
REQ-015 SHALL have port state  output  2  FSM state: HUNT=0, SYNC=1, LOCKED=2.

Function
REQ-016 SHALL descramble using the self-synchronous polynomial 1+x^14+x^15: d[n] = s[n] ^ s[n-14] ^ s[n-15], with n in serial bit order per REQ-008.
REQ-017 SHALL keep the last 15 received scrambled bits in a 15-bit history register; update it only on in_valid; reset value 0.
REQ-018 SHALL register out_data and out_valid one cycle after in_valid; out_valid = in_valid delayed by 1 cycle; out_data holds its value when out_valid=0.
REQ-019 SHALL define a word as consistent when octet k = octet0 + k mod 256, for k = 1..3.
REQ-020 SHALL compute expected_next = word + 0x04 per octet, mod 256 per octet, with no inter-octet carry.
REQ-021 SHALL, in HUNT, on a consistent out_valid word, seed expected_next from it, set match_cnt=1 and go to SYNC; inconsistent words keep the FSM in HUNT.
REQ-022 SHALL, in SYNC, on a word equal to expected: increment match_cnt and advance expected.
REQ-023 SHALL go to LOCKED when match_cnt reaches LOCK_COUNT+1 (the seed plus LOCK_COUNT matches).
REQ-024 SHALL, in SYNC, on a mismatch: go to HUNT with match_cnt=0; the mismatching word is not used as a seed.
REQ-025 SHALL, in LOCKED, always advance expected from expected, never from received data.
REQ-026 SHALL, in LOCKED, on a mismatch: pulse error, increment error_count and increment miss_cnt; a match resets miss_cnt to 0.
REQ-027 SHALL return to HUNT, with locked deasserting, when miss_cnt reaches 3.
REQ-028 SHALL assert error, locked and state updates one cycle after the corresponding out_valid word (two cycles after in_valid).
REQ-029 SHALL saturate error_count at all-ones.
REQ-030 SHALL let clear take priority over a simultaneous error: error_count=0 that cycle, while the error pulse still asserts.
REQ-031 SHALL hold all FSM and expected state on cycles with out_valid=0.

Reset
REQ-032 SHALL, while resetn=0, asynchronously force: out_valid=0, out_data=0, history=0, state=HUNT, locked=0, error=0, error_count=0, match_cnt=0, miss_cnt=0, expected=0.
REQ-033 SHALL resume normal operation on the first rising clk edge after resetn deasserts; no extra warm-up cycles.

Verification
REQ-034 SHALL cover: jesd204 scrambler (state 0) fed ramp 0x03020100 +0x04040404 per word, continuous in_valid -> out_data = 0x03020100 one cycle after first in_valid; locked=1 after the 5th output word; error_count stays 0.
REQ-035 SHALL cover: while LOCKED, flip in_data[7] of one word -> error pulses on 1 or 2 words (15-bit error propagation); error_count = 1 or 2; locked stays 1.
REQ-036 SHALL cover: while LOCKED, drive 3 consecutive words of 0xFFFFFFFF, then resume the ramp -> error_count +3; state HUNT; relock after 5 good output words (the first 2 may be corrupt through the history register).
REQ-037 SHALL cover: ramp with in_valid toggling 1,0,0,1 pattern -> no errors; locked held; out_valid mirrors in_valid delayed by 1 cycle.
REQ-038 SHALL cover: clear asserted on the same cycle as an error pulse with error_count=5 -> error_count=0 next cycle; error pulse visible.
REQ-039 SHALL cover: resetn low mid-LOCKED, asynchronous to clk -> outputs reach reset values before the next clk edge; relock after reset behaves as in REQ-034.
